fpresult: RTL and testbench
===========================

// Module: fpresult
// PURPOSE
// - Final FPU stage, directly downstream of the exception stage (fpexc) and the normaliser/rounder.
// - Assembles the IEEE-754 result word from sign, exponent and mantissa, applying the exception
//   controls (Exp_toZero/Exp_toInf/Mant_toZero).
// - Registers the word plus per-op flags behind a 2-entry skid buffer with valid/ready.
// - Accumulates sticky fflags for the core CSR.
// PARAMETERS
// - C_QNAN   32'h7FC0_0000  canonical quiet NaN, used only with FPRES_CANON_NAN_EN
// - C_FLAGS  5              fflags width, bit order {NV,DZ,OF,UF,NX}; DZ is always 0
// PORTS
// - Clk_CI          in   1        clock
// - Rst_RBI         in   1        asynchronous active-low reset
// - Valid_SI        in   1        upstream op valid
// - Ready_SO        out  1        stage can accept
// - Op_SI           in   C_CMD    op code
// - Sign_res_DI     in   1        result sign
// - Exp_res_DI      in   C_EXP    rounded exponent
// - Mant_norm_DI    in   C_MANT+1 normalised mantissa, MSB is the hidden bit
// - Int_res_DI      in   C_OP     F2I integer result
// - Exp_toZero_SI, Exp_toInf_SI, Mant_toZero_SI   in  1 each  exception controls
// - OF_SI, UF_SI, Zero_SI, IX_SI, IV_SI, Inf_SI   in  1 each  per-op flags
// - Valid_SO        out  1        result valid
// - Ready_SI        in   1        downstream accepts
// - Result_DO       out  C_OP     assembled result
// - OF_SO, UF_SO, Zero_SO, IX_SO, IV_SO, Inf_SO   out 1 each  flags aligned with Result_DO
// - Flush_SI        in   1        sync drop of all buffered ops
// - FflagsClr_SI    in   1        clear sticky flags
// - Fflags_DO       out  C_FLAGS  sticky flags
// BEHAVIOUR
// - Reset (async, Rst_RBI=0):
//   - all outputs 0, except Ready_SO=1
//   - skid empty, Fflags_DO=0
// - Assembly (combinational, before buffer):
//   - F2I: word = Int_res_DI
//   - else: exp = Exp_toInf ? all-ones : Exp_toZero ? 0 : Exp_res_DI
//   - else: man = Mant_toZero ? 0 : Mant_norm_DI[C_MANT-1:0]
//   - else: word = {Sign_res_DI, exp, man}
// - Handshake:
//   - input transfer on Valid_SI & Ready_SO; output transfer on Valid_SO & Ready_SI
//   - latency 1 cycle: an op accepted at edge N is visible at Valid_SO after edge N
//   - throughput 1 op/cycle while Ready_SI=1
// - Skid FSM, states EMPTY / ONE / FULL:
//   - EMPTY -in-> ONE
//   - ONE: in & out stay ONE; in & ~out -> FULL; out & ~in -> EMPTY
//   - FULL -out-> ONE
//   - Ready_SO = (state != FULL) and is registered
//   - FULL with Valid_SI=1 holds the input; no op is lost
// - Output stability: Result_DO and flags hold stable while Valid_SO & ~Ready_SI.
// - Flush_SI: next state EMPTY; no sticky update that cycle, even if an output transfer occurs.
// - Sticky fflags:
//   - on each output transfer: Fflags |= {IV,0,OF,UF,IX} of the transferred op
//   - FflagsClr_SI alone sets Fflags to 0 next cycle
//   - FflagsClr_SI with a transfer in the same cycle: Fflags = new op flags only (clear first, then OR)
//   - reset mid-operation discards buffered ops and sticky state
// CONFIGURATION
// - FPRES_CANON_NAN_EN defined: any non-F2I op with IV_SI=1 yields Result = C_QNAN.
// - FPRES_CANON_NAN_EN undefined: plain assembly; IV yields sign/all-ones exp/normalised mantissa.
// - Flags are identical in both builds.
// STRUCTURE
// - fpu_defs gains: C_OP, C_FLAGS, C_QNAN, the flag-bit index constants, and an enum for the
//   skid states.
// - Sub-module fpresult_skid: generic 2-entry valid/ready skid buffer, parameterised on a packed
//   payload {word, 6 flags}.
// - Assembly and sticky logic stay in fpresult.
// TESTING (C_EXP=8, C_MANT=23)
// - ADD, Exp_res=8'h7F, Mant_norm=24'h800000, sign 0 -> one cycle later Result=32'h3F80_0000, Valid_SO=1.
// - MUL, Exp_toInf=1, Mant_toZero=1, OF=1, IX=1 -> Result=32'h7F80_0000; after transfer Fflags=5'b00101.
// - ADD, IV=1, Exp_toInf=1 -> Result=32'h7FC0_0000 with macro; without macro, exp field FF and mantissa passes through.
// - Ready_SI=0 for 3 cycles, Valid_SI=1 with ops A,B,C -> Ready_SO=0 after B; A then B then C delivered in order, none lost.
// - FflagsClr_SI plus transfer of an op with UF=1 while Fflags=5'b10000 -> Fflags=5'b00010.
// - Rst_RBI low for one cycle while FULL -> Valid_SO=0, Fflags=0, Ready_SO=1 immediately.

Source files
------------

// File: rtl/fpresult_pkg.sv
// Shared constants, op codes, flag indices and skid-state enum for the FPU result stage.
package fpresult_pkg;
    localparam int C_EXP   = 8;
    localparam int C_MANT  = 23;
    localparam int C_OP    = 32;
    localparam int C_CMD   = 3;
    localparam int C_FLAGS = 5;
    localparam int C_NPF   = 6;

    localparam logic [C_OP-1:0] C_QNAN = 32'h7FC0_0000;

    localparam logic [C_CMD-1:0] C_FPU_ADD_CMD = 3'd0;
    localparam logic [C_CMD-1:0] C_FPU_SUB_CMD = 3'd1;
    localparam logic [C_CMD-1:0] C_FPU_MUL_CMD = 3'd2;
    localparam logic [C_CMD-1:0] C_FPU_DIV_CMD = 3'd3;
    localparam logic [C_CMD-1:0] C_FPU_I2F_CMD = 3'd4;
    localparam logic [C_CMD-1:0] C_FPU_F2I_CMD = 3'd5;

    // Sticky fflags bit positions {NV,DZ,OF,UF,NX}
    localparam int C_FFLAG_NV = 4;
    localparam int C_FFLAG_DZ = 3;
    localparam int C_FFLAG_OF = 2;
    localparam int C_FFLAG_UF = 1;
    localparam int C_FFLAG_NX = 0;

    // Per-op flag bit positions inside the buffered payload
    localparam int C_PF_OF   = 5;
    localparam int C_PF_UF   = 4;
    localparam int C_PF_ZERO = 3;
    localparam int C_PF_IX   = 2;
    localparam int C_PF_IV   = 1;
    localparam int C_PF_INF  = 0;

    typedef enum logic [1:0] {SKID_EMPTY, SKID_ONE, SKID_FULL} skid_state_e;

    typedef struct packed {
        logic [C_OP-1:0]  word;
        logic [C_NPF-1:0] flags;
    } res_t;
endpackage

// File: rtl/fpresult_if.sv
// Handshake and data bundle of the result stage; slave = stage view, master = driver view.
interface fpresult_if;
    import fpresult_pkg::*;

    logic                Valid_SI, Ready_SO;
    logic [C_CMD-1:0]    Op_SI;
    logic                Sign_res_DI;
    logic [C_EXP-1:0]    Exp_res_DI;
    logic [C_MANT:0]     Mant_norm_DI;
    logic [C_OP-1:0]     Int_res_DI;
    logic                Exp_toZero_SI, Exp_toInf_SI, Mant_toZero_SI;
    logic                OF_SI, UF_SI, Zero_SI, IX_SI, IV_SI, Inf_SI;
    logic                Valid_SO, Ready_SI;
    logic [C_OP-1:0]     Result_DO;
    logic                OF_SO, UF_SO, Zero_SO, IX_SO, IV_SO, Inf_SO;
    logic                Flush_SI, FflagsClr_SI;
    logic [C_FLAGS-1:0]  Fflags_DO;

    modport slave (
        input  Valid_SI, Op_SI, Sign_res_DI, Exp_res_DI, Mant_norm_DI, Int_res_DI,
               Exp_toZero_SI, Exp_toInf_SI, Mant_toZero_SI,
               OF_SI, UF_SI, Zero_SI, IX_SI, IV_SI, Inf_SI,
               Ready_SI, Flush_SI, FflagsClr_SI,
        output Ready_SO, Valid_SO, Result_DO,
               OF_SO, UF_SO, Zero_SO, IX_SO, IV_SO, Inf_SO, Fflags_DO
    );

    modport master (
        output Valid_SI, Op_SI, Sign_res_DI, Exp_res_DI, Mant_norm_DI, Int_res_DI,
               Exp_toZero_SI, Exp_toInf_SI, Mant_toZero_SI,
               OF_SI, UF_SI, Zero_SI, IX_SI, IV_SI, Inf_SI,
               Ready_SI, Flush_SI, FflagsClr_SI,
        input  Ready_SO, Valid_SO, Result_DO,
               OF_SO, UF_SO, Zero_SO, IX_SO, IV_SO, Inf_SO, Fflags_DO
    );
endinterface

// File: rtl/fpresult_skid.sv
// Generic 2-entry valid/ready skid buffer; head register drives the output, skid catches
// the op that arrives while the head is stalled.
module fpresult_skid
    import fpresult_pkg::*;
#(
    parameter int W = 38
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);
    skid_state_e  r_state;
    logic [W-1:0] r_head, r_skid;
    logic         r_ready, r_valid;
    logic         w_in, w_out;

    assign w_in    = i_valid & r_ready;
    assign w_out   = r_valid & i_ready;
    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_data  = r_head;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SKID_EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_state <= SKID_EMPTY;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                SKID_EMPTY: if (w_in) begin
                    r_head  <= i_data;
                    r_state <= SKID_ONE;
                    r_valid <= 1'b1;
                end
                SKID_ONE: begin
                    if (w_in && w_out) begin
                        r_head <= i_data;
                    end else if (w_in) begin
                        r_skid  <= i_data;
                        r_state <= SKID_FULL;
                        r_ready <= 1'b0;
                    end else if (w_out) begin
                        r_state <= SKID_EMPTY;
                        r_valid <= 1'b0;
                    end
                end
                SKID_FULL: if (w_out) begin
                    r_head  <= r_skid;
                    r_state <= SKID_ONE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= SKID_EMPTY;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/fpresult.sv
// FPU result stage: assembles the IEEE-754 word, buffers it with its flags, keeps sticky fflags.
// Optional build macro FPRES_CANON_NAN_EN: invalid non-F2I ops return the canonical quiet NaN.
module fpresult
    import fpresult_pkg::*;
(
    input logic        Clk_CI,
    input logic        Rst_RBI,
    fpresult_if.slave  io
);
`ifdef FPRES_CANON_NAN_EN
    localparam bit C_CANON = 1'b1;
`else
    localparam bit C_CANON = 1'b0;
`endif

    logic [C_EXP-1:0]   w_exp;
    logic [C_MANT-1:0]  w_man;
    logic [C_OP-1:0]    w_word;
    res_t               w_pay_in, w_pay_out;
    logic               w_xfer;
    logic [C_FLAGS-1:0] w_newf;
    logic [C_FLAGS-1:0] r_fflags;
    // The hidden bit is implied by the packed format and never stored.
    logic               w_unused_hidden;

    assign w_unused_hidden = io.Mant_norm_DI[C_MANT];

    always_comb begin
        w_exp  = io.Exp_toInf_SI ? '1 : (io.Exp_toZero_SI ? '0 : io.Exp_res_DI);
        w_man  = io.Mant_toZero_SI ? '0 : io.Mant_norm_DI[C_MANT-1:0];
        w_word = {io.Sign_res_DI, w_exp, w_man};
        if (C_CANON && io.IV_SI)
            w_word = C_QNAN;
        if (io.Op_SI == C_FPU_F2I_CMD)
            w_word = io.Int_res_DI;
    end

    assign w_pay_in.word  = w_word;
    assign w_pay_in.flags = {io.OF_SI, io.UF_SI, io.Zero_SI, io.IX_SI, io.IV_SI, io.Inf_SI};

    fpresult_skid #(.W($bits(res_t))) u_skid (
        .i_clk   (Clk_CI),
        .i_rst_n (Rst_RBI),
        .i_flush (io.Flush_SI),
        .i_valid (io.Valid_SI),
        .o_ready (io.Ready_SO),
        .i_data  (w_pay_in),
        .o_valid (io.Valid_SO),
        .i_ready (io.Ready_SI),
        .o_data  (w_pay_out)
    );

    assign io.Result_DO = w_pay_out.word;
    assign io.OF_SO     = w_pay_out.flags[C_PF_OF];
    assign io.UF_SO     = w_pay_out.flags[C_PF_UF];
    assign io.Zero_SO   = w_pay_out.flags[C_PF_ZERO];
    assign io.IX_SO     = w_pay_out.flags[C_PF_IX];
    assign io.IV_SO     = w_pay_out.flags[C_PF_IV];
    assign io.Inf_SO    = w_pay_out.flags[C_PF_INF];

    // A flushed transfer never reaches the architectural flags.
    assign w_xfer = io.Valid_SO & io.Ready_SI & ~io.Flush_SI;

    always_comb begin
        w_newf             = '0;
        w_newf[C_FFLAG_NV] = w_pay_out.flags[C_PF_IV];
        w_newf[C_FFLAG_DZ] = 1'b0;
        w_newf[C_FFLAG_OF] = w_pay_out.flags[C_PF_OF];
        w_newf[C_FFLAG_UF] = w_pay_out.flags[C_PF_UF];
        w_newf[C_FFLAG_NX] = w_pay_out.flags[C_PF_IX];
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI)
            r_fflags <= '0;
        else if (io.FflagsClr_SI || w_xfer)
            r_fflags <= (io.FflagsClr_SI ? '0 : r_fflags) | (w_xfer ? w_newf : '0);
    end

    assign io.Fflags_DO = r_fflags;
endmodule

// File: tb/tb_fpresult.sv
// Directed, table-driven bench for fpresult; expected words and sticky flags are hand-computed.
module tb_fpresult;
    import fpresult_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;
        logic [31:0] ires;
        logic        ez, ei, mz;
        logic [5:0]  fl;     // {OF,UF,Zero,IX,IV,Inf}
        logic [31:0] res;
        logic [4:0]  ff;     // sticky fflags after the op has been delivered
    } vec_t;

    logic clk, rst_n;
    int   npass, ntotal;
    vec_t tbl[8];
    vec_t v;

    fpresult_if io();
    fpresult dut (.Clk_CI(clk), .Rst_RBI(rst_n), .io(io));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] op, input logic sign, input logic [7:0] exp,
                                input logic [23:0] mant, input logic [31:0] ires,
                                input logic ez, input logic ei, input logic mz,
                                input logic [5:0] fl, input logic [31:0] res, input logic [4:0] ff);
        vec_t r;
        r.op = op; r.sign = sign; r.exp = exp; r.mant = mant; r.ires = ires;
        r.ez = ez; r.ei = ei; r.mz = mz; r.fl = fl; r.res = res; r.ff = ff;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input vec_t x);
        io.Op_SI = x.op; io.Sign_res_DI = x.sign; io.Exp_res_DI = x.exp;
        io.Mant_norm_DI = x.mant; io.Int_res_DI = x.ires;
        io.Exp_toZero_SI = x.ez; io.Exp_toInf_SI = x.ei; io.Mant_toZero_SI = x.mz;
        {io.OF_SI, io.UF_SI, io.Zero_SI, io.IX_SI, io.IV_SI, io.Inf_SI} = x.fl;
    endtask

    function automatic logic [5:0] oflags();
        return {io.OF_SO, io.UF_SO, io.Zero_SO, io.IX_SO, io.IV_SO, io.Inf_SO};
    endfunction

    task automatic cyc();
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        logic [31:0] nan_res;
`ifdef FPRES_CANON_NAN_EN
        nan_res = 32'h7FC0_0000;
`else
        nan_res = 32'h7FA0_0000;
`endif
        npass = 0; ntotal = 0;
        tbl[0] = mk(C_FPU_ADD_CMD, 0, 8'h7F, 24'h800000, 0,            0,0,0, 6'b000000, 32'h3F80_0000, 5'b00000);
        tbl[1] = mk(C_FPU_MUL_CMD, 0, 8'h12, 24'h000009, 0,            0,1,1, 6'b100100, 32'h7F80_0000, 5'b00101);
        tbl[2] = mk(C_FPU_ADD_CMD, 0, 8'h55, 24'hA00000, 0,            0,1,0, 6'b000010, nan_res,       5'b10101);
        tbl[3] = mk(C_FPU_F2I_CMD, 1, 8'h33, 24'h123456, 32'hDEADBEEF, 1,1,1, 6'b001000, 32'hDEAD_BEEF, 5'b10101);
        tbl[4] = mk(C_FPU_SUB_CMD, 1, 8'h80, 24'hFFFFFF, 0,            1,0,0, 6'b010100, 32'h807F_FFFF, 5'b10111);
        tbl[5] = mk(C_FPU_F2I_CMD, 0, 8'h00, 24'h000000, 32'h7FFFFFFF, 0,0,0, 6'b000110, 32'h7FFF_FFFF, 5'b10111);
        tbl[6] = mk(C_FPU_DIV_CMD, 1, 8'h40, 24'hC00001, 0,            1,0,1, 6'b011000, 32'h8000_0000, 5'b10111);
        tbl[7] = mk(C_FPU_ADD_CMD, 1, 8'h01, 24'h800000, 0,            0,1,1, 6'b100101, 32'hFF80_0000, 5'b10111);

        rst_n = 1'b0;
        io.Valid_SI = 0; io.Ready_SI = 1; io.Flush_SI = 0; io.FflagsClr_SI = 0;
        drive(tbl[0]);
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, io.Ready_SO}, 1);
        chk("rst_valid", {31'd0, io.Valid_SO}, 0);
        chk("rst_result", io.Result_DO, 0);
        chk("rst_flags", {26'd0, oflags()}, 0);
        chk("rst_fflags", {27'd0, io.Fflags_DO}, 0);
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i]);
            io.Valid_SI = 1;
            cyc();
            chk($sformatf("vec%0d_valid", i), {31'd0, io.Valid_SO}, 1);
            chk($sformatf("vec%0d_result", i), io.Result_DO, tbl[i].res);
            chk($sformatf("vec%0d_flags", i), {26'd0, oflags()}, {26'd0, tbl[i].fl});
            io.Valid_SI = 0;
            cyc();
            chk($sformatf("vec%0d_drained", i), {31'd0, io.Valid_SO}, 0);
            chk($sformatf("vec%0d_fflags", i), {27'd0, io.Fflags_DO}, {27'd0, tbl[i].ff});
        end

        io.FflagsClr_SI = 1;
        cyc();
        io.FflagsClr_SI = 0;
        chk("clr_alone", {27'd0, io.Fflags_DO}, 0);

        // Seed NV, then stall output for three cycles while A,B,C arrive
        drive(mk(C_FPU_ADD_CMD, 0, 8'h10, 24'h800000, 0, 0,0,0, 6'b000010, 0, 0));
        io.Valid_SI = 1; cyc(); io.Valid_SI = 0; cyc();
        chk("seed_nv", {27'd0, io.Fflags_DO}, 32'b10000);

        io.Ready_SI = 0;
        drive(mk(C_FPU_ADD_CMD, 0, 8'h01, 24'h800000, 0, 0,0,0, 6'b000000, 0, 0));
        io.Valid_SI = 1;
        cyc();
        chk("stall_a_valid", {31'd0, io.Valid_SO}, 1);
        chk("stall_a_ready", {31'd0, io.Ready_SO}, 1);
        chk("stall_a_res", io.Result_DO, 32'h0080_0000);
        drive(mk(C_FPU_ADD_CMD, 0, 8'h02, 24'h800000, 0, 0,0,0, 6'b000000, 0, 0));
        cyc();
        chk("full_ready", {31'd0, io.Ready_SO}, 0);
        chk("full_hold_a", io.Result_DO, 32'h0080_0000);
        drive(mk(C_FPU_ADD_CMD, 0, 8'h03, 24'h800000, 0, 0,0,0, 6'b010000, 0, 0));
        cyc();
        chk("full_c_held", {31'd0, io.Ready_SO}, 0);
        chk("full_hold_a2", io.Result_DO, 32'h0080_0000);
        io.Ready_SI = 1;
        cyc();
        chk("order_b", io.Result_DO, 32'h0100_0000);
        chk("order_b_ready", {31'd0, io.Ready_SO}, 1);
        cyc();
        chk("order_c", io.Result_DO, 32'h0180_0000);
        chk("order_c_uf", {31'd0, io.UF_SO}, 1);
        chk("pre_clr_ff", {27'd0, io.Fflags_DO}, 32'b10000);
        io.Valid_SI = 0;
        io.FflagsClr_SI = 1;
        cyc();
        io.FflagsClr_SI = 0;
        chk("c_drained", {31'd0, io.Valid_SO}, 0);
        chk("clr_with_xfer", {27'd0, io.Fflags_DO}, 32'b00010);

        // Fill to FULL, then pulse reset between edges
        io.Ready_SI = 0;
        drive(mk(C_FPU_MUL_CMD, 0, 8'h20, 24'h800000, 0, 0,0,0, 6'b100100, 0, 0));
        io.Valid_SI = 1;
        cyc(); cyc();
        io.Valid_SI = 0;
        chk("pre_rst_full", {31'd0, io.Ready_SO}, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, io.Valid_SO}, 0);
        chk("midrst_ready", {31'd0, io.Ready_SO}, 1);
        chk("midrst_fflags", {27'd0, io.Fflags_DO}, 0);
        cyc();
        rst_n = 1'b1;
        io.Ready_SI = 1;
        cyc();
        chk("post_rst_empty", {31'd0, io.Valid_SO}, 0);

        // Flush coinciding with an output transfer must not touch the sticky flags
        drive(mk(C_FPU_ADD_CMD, 0, 8'h05, 24'h800000, 0, 0,0,0, 6'b000010, 0, 0));
        io.Valid_SI = 1;
        cyc();
        chk("flush_pre_valid", {31'd0, io.Valid_SO}, 1);
        io.Valid_SI = 0;
        io.Flush_SI = 1;
        cyc();
        io.Flush_SI = 0;
        chk("flush_valid", {31'd0, io.Valid_SO}, 0);
        chk("flush_no_sticky", {27'd0, io.Fflags_DO}, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
